// File: rtl/wb_master_port_pkg.sv
// Shared bus-operation codes, FSM/size encodings and op decode helpers.
// No logic of its own; imported by the Wishbone master and its lane steering.
// No flow control.
package wb_master_port_pkg;

    localparam logic [2:0] BUSOP_READB  = 3'd0;
    localparam logic [2:0] BUSOP_READH  = 3'd1;
    localparam logic [2:0] BUSOP_READW  = 3'd2;
    localparam logic [2:0] BUSOP_READBU = 3'd3;
    localparam logic [2:0] BUSOP_READHU = 3'd4;
    localparam logic [2:0] BUSOP_WRITEB = 3'd5;
    localparam logic [2:0] BUSOP_WRITEH = 3'd6;
    localparam logic [2:0] BUSOP_WRITEW = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    function automatic size_t op_size(input logic [2:0] op);
        case (op)
            BUSOP_READB, BUSOP_READBU, BUSOP_WRITEB: return SZ_B;
            BUSOP_READH, BUSOP_READHU, BUSOP_WRITEH: return SZ_H;
            default:                                 return SZ_W;
        endcase
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return (op == BUSOP_READB) || (op == BUSOP_READH);
    endfunction

    function automatic logic op_write(input logic [2:0] op);
        return (op == BUSOP_WRITEB) || (op == BUSOP_WRITEH) || (op == BUSOP_WRITEW);
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] addr_lo);
        case (sz)
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_lane_steer.sv
// Byte-lane steering: write data replication/shift with byte enables, read extract with extension.
// Latency: purely combinational.
// Backpressure: none.
module wb_lane_steer
    import wb_master_port_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  size_t                       size,
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  logic                        sign,
    input  logic [31:0]                 wdata,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W/8-1:0]         sel,
    output logic [DATA_W-1:0]           wdat,
    output logic [31:0]                 rext
);

    logic [DATA_W/8-1:0] mask;
    logic [DATA_W-1:0]   shifted;

    always_comb begin
        mask = '0;
        case (size)
            SZ_B:    mask[0]   = 1'b1;
            SZ_H:    mask[1:0] = 2'b11;
            default: mask[3:0] = 4'hF;
        endcase
        sel  = mask << lane;
        wdat = {(DATA_W/32){wdata}} << {lane, 3'b000};
    end

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (size)
            SZ_B:    rext = {{24{sign & shifted[7]}}, shifted[7:0]};
            SZ_H:    rext = {{16{sign & shifted[15]}}, shifted[15:0]};
            default: rext = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/wb_master_port.sv
// Wishbone B4 classic master: one CPU load/store becomes at most one bus cycle.
// Latency: O_done two cycles after acceptance with a zero-wait slave; one cycle for misaligned requests.
// Backpressure: O_busy high until O_done; I_en ignored outside IDLE; bounded ACK wait unless TIMEOUT=0.
module wb_master_port
    import wb_master_port_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                I_en,
    input  logic [2:0]          I_op,
    input  logic [ADDR_W-1:0]   I_addr,
    input  logic [31:0]         I_data,
    output logic [31:0]         O_data,
    output logic                O_busy,
    output logic                O_done,
    output logic                O_err,
    input  logic                ACK_I,
    input  logic                ERR_I,
    input  logic [DATA_W-1:0]   DAT_I,
    output logic [ADDR_W-1:0]   ADR_O,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [DATA_W/8-1:0] SEL_O,
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O
);

    localparam int LANE_W = $clog2(DATA_W/8);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    state_t              state, state_nxt;
    size_t               size_d, size_q, st_size;
    logic [LANE_W-1:0]   lane_q, st_lane;
    logic                sign_q, write_q, err_q, st_sign;
    logic                misal_d, timed_out, bus_end;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W/8-1:0] sel_w;
    logic [DATA_W-1:0]   wdat_w;
    logic [31:0]         rext_w;

    assign size_d    = op_size(I_op);
    assign misal_d   = misaligned(size_d, I_addr[1:0]);
    assign timed_out = (TIMEOUT != 0) && (cnt == TO_LIM);
    assign bus_end   = (state == ST_BUS) && (ACK_I || ERR_I || timed_out);

    // Write steering only matters at acceptance, read extraction only in BUS,
    // so one steering block serves both from live or latched request fields.
    assign st_size = (state == ST_IDLE) ? size_d : size_q;
    assign st_lane = (state == ST_IDLE) ? I_addr[LANE_W-1:0] : lane_q;
    assign st_sign = (state == ST_IDLE) ? op_signed(I_op) : sign_q;

    wb_lane_steer #(.DATA_W(DATA_W)) u_steer (
        .size  (st_size),
        .lane  (st_lane),
        .sign  (st_sign),
        .wdata (I_data),
        .rdata (DAT_I),
        .sel   (sel_w),
        .wdat  (wdat_w),
        .rext  (rext_w)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (I_en) state_nxt = misal_d ? ST_DONE : ST_BUS;
            ST_BUS:  if (bus_end) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            size_q  <= SZ_B;
            lane_q  <= '0;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
            O_data  <= '0;
            ADR_O   <= '0;
            DAT_O   <= '0;
            SEL_O   <= '0;
            CYC_O   <= 1'b0;
            STB_O   <= 1'b0;
            WE_O    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_en) begin
                        size_q  <= size_d;
                        lane_q  <= I_addr[LANE_W-1:0];
                        sign_q  <= op_signed(I_op);
                        write_q <= op_write(I_op);
                        err_q   <= misal_d;
                        cnt     <= '0;
                        if (!misal_d) begin
                            ADR_O <= {I_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            DAT_O <= wdat_w;
                            SEL_O <= sel_w;
                            WE_O  <= op_write(I_op);
                            CYC_O <= 1'b1;
                            STB_O <= 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_end) begin
                        CYC_O <= 1'b0;
                        STB_O <= 1'b0;
                        WE_O  <= 1'b0;
                        SEL_O <= '0;
                        // ERR beats ACK; ACK beats a same-edge timeout.
                        err_q <= ERR_I || !ACK_I;
                        if (ACK_I && !ERR_I && !write_q) O_data <= rext_w;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_busy = (state != ST_IDLE);
    assign O_done = (state == ST_DONE);
    assign O_err  = O_done && err_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Bench for wb_master_port: 32- and 64-bit instances driven in lockstep, scoreboard per instance.
module tb_wb_master_port;
    import wb_master_port_pkg::*;

    localparam int TO = 4;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        en, ack, err;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic [63:0] dat_i;

    logic [31:0] a_odata, a_adr, a_dat;
    logic [3:0]  a_sel;
    logic        a_busy, a_done, a_err, a_cyc, a_stb, a_we;
    logic [31:0] b_odata, b_adr;
    logic [63:0] b_dat;
    logic [7:0]  b_sel;
    logic        b_busy, b_done, b_err, b_cyc, b_stb, b_we;
    logic [31:0] dat_i32;

    assign dat_i32 = dat_i[31:0];

    always #5 CLK_I = ~CLK_I;

    wb_master_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut32 (
        .CLK_I(CLK_I), .RST_I(RST_I), .I_en(en), .I_op(op), .I_addr(addr), .I_data(wdata),
        .O_data(a_odata), .O_busy(a_busy), .O_done(a_done), .O_err(a_err),
        .ACK_I(ack), .ERR_I(err), .DAT_I(dat_i32), .ADR_O(a_adr), .DAT_O(a_dat),
        .SEL_O(a_sel), .CYC_O(a_cyc), .STB_O(a_stb), .WE_O(a_we));

    wb_master_port #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO)) dut64 (
        .CLK_I(CLK_I), .RST_I(RST_I), .I_en(en), .I_op(op), .I_addr(addr), .I_data(wdata),
        .O_data(b_odata), .O_busy(b_busy), .O_done(b_done), .O_err(b_err),
        .ACK_I(ack), .ERR_I(err), .DAT_I(dat_i), .ADR_O(b_adr), .DAT_O(b_dat),
        .SEL_O(b_sel), .CYC_O(b_cyc), .STB_O(b_stb), .WE_O(b_we));

    typedef struct packed {
        int          issue;
        int          done_cyc;
        int          stb_n;
        bit          err;
        bit          we;
        logic [7:0]  sel;
        logic [31:0] adr;
        logic [63:0] dat;
        logic [31:0] odata;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          stb_cnt[2];
    logic [31:0] last[2];

    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte-lane view of a request on a bus of nb bytes.
    // mode: 0 ack, 1 err, 2 silent slave, 3 err+ack together.
    function automatic exp_t model(input int nb, input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [63:0] rd, input int mode,
                                   input int waits, input logic [31:0] prev, input int issue);
        exp_t        e;
        int          n, lane;
        bit          wr, sg;
        logic [31:0] r;
        n    = (o == BUSOP_READB || o == BUSOP_READBU || o == BUSOP_WRITEB) ? 1 :
               (o == BUSOP_READH || o == BUSOP_READHU || o == BUSOP_WRITEH) ? 2 : 4;
        wr   = (o == BUSOP_WRITEB || o == BUSOP_WRITEH || o == BUSOP_WRITEW);
        sg   = (o == BUSOP_READB || o == BUSOP_READH);
        lane = int'(a % nb);
        e         = '0;
        e.issue   = issue;
        e.we      = wr;
        e.adr     = a - lane;
        for (int j = 0; j < nb; j++) begin
            if (j >= lane && j < lane + n) e.sel[j] = 1'b1;
            if (j >= lane) e.dat[8*j +: 8] = wd[8*((j - lane) % 4) +: 8];
        end
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = rd[8*(lane + k) +: 8];
        if (sg && r[8*n - 1]) for (int k = n; k < 4; k++) r[8*k +: 8] = 8'hFF;
        if ((a % n) != 0) begin
            e.err      = 1'b1;
            e.stb_n    = 0;
            e.done_cyc = issue + 1;
            e.odata    = prev;
        end else begin
            e.stb_n    = (mode == 2) ? TO + 1 : waits + 1;
            e.done_cyc = issue + 1 + e.stb_n;
            e.err      = (mode != 0);
            e.odata    = (mode == 0 && !wr) ? r : prev;
        end
        return e;
    endfunction

    task automatic mon(input int d, input logic c_o, input logic s_o, input logic w_o,
                       input logic [7:0] sel, input logic [31:0] adr, input logic [63:0] dat,
                       input logic busy, input logic dn, input logic er, input logic [31:0] od);
        exp_t  e;
        bit    have;
        string p;
        p    = (d == 0) ? "w32" : "w64";
        have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        e    = '0;
        if (have) begin
            if (d == 0) e = q0[0];
            else        e = q1[0];
        end
        if (have && cyc > e.issue) begin
            if (dn) begin
                chk({p, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
                chk({p, "_err"}, 64'(er), 64'(e.err));
                chk({p, "_odata"}, 64'(od), 64'(e.odata));
                chk({p, "_stb_cycles"}, 64'(stb_cnt[d]), 64'(e.stb_n));
                chk({p, "_busy_at_done"}, 64'(busy), 64'd1);
                chk({p, "_cyc_at_done"}, 64'(c_o), 64'd0);
                if (d == 0) q0.delete(0);
                else        q1.delete(0);
                stb_cnt[d] = 0;
            end else if (cyc >= e.done_cyc) begin
                checks++;
                errors++;
                $display("FAIL %s_done_missing: no O_done by cycle %0d, expected at %0d", p, cyc, e.done_cyc);
                if (d == 0) q0.delete(0);
                else        q1.delete(0);
                stb_cnt[d] = 0;
            end else begin
                chk({p, "_busy"}, 64'(busy), 64'd1);
                chk({p, "_stb_eq_cyc"}, 64'(s_o), 64'(c_o));
                if (c_o) begin
                    stb_cnt[d]++;
                    chk({p, "_sel"}, 64'(sel), 64'(e.sel));
                    chk({p, "_adr"}, 64'(adr), 64'(e.adr));
                    chk({p, "_we"}, 64'(w_o), 64'(e.we));
                    chk({p, "_dat_o"}, dat, e.dat);
                end
            end
        end else begin
            chk({p, "_idle_cyc"}, 64'(c_o), 64'd0);
            chk({p, "_idle_done"}, 64'(dn), 64'd0);
            chk({p, "_idle_busy"}, 64'(busy), 64'd0);
        end
    endtask

    always @(negedge CLK_I) begin
        if (mon_en) begin
            mon(0, a_cyc, a_stb, a_we, {4'b0, a_sel}, a_adr, {32'b0, a_dat}, a_busy, a_done, a_err, a_odata);
            mon(1, b_cyc, b_stb, b_we, b_sel, b_adr, b_dat, b_busy, b_done, b_err, b_odata);
        end
    end

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic junk(input bit en_j);
        en    = en_j;
        op    = 3'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        ack   = 1'($urandom);
        err   = 1'($urandom);
        dat_i = {$urandom, $urandom};
    endtask

    task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                          input logic [63:0] rd, input int mode, input int waits);
        exp_t e0, e1;
        step();
        junk(1'b1);
        op    = o;
        addr  = a;
        wdata = wd;
        e0 = model(4, o, a, wd, rd, mode, waits, last[0], cyc);
        e1 = model(8, o, a, wd, rd, mode, waits, last[1], cyc);
        last[0] = e0.odata;
        last[1] = e1.odata;
        q0.push_back(e0);
        q1.push_back(e1);
        for (int i = 0; i < e0.stb_n; i++) begin
            step();
            junk(1'b1);
            ack = 1'b0;
            err = 1'b0;
            if (i == e0.stb_n - 1 && mode != 2) begin
                dat_i = rd;
                ack   = (mode == 0 || mode == 3);
                err   = (mode == 1 || mode == 3);
            end
        end
        step();
        junk(1'b1);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            junk(1'b0);
        end
    endtask

    initial begin
        int m, md;
        RST_I = 1'b1;
        en = 1'b0; op = '0; addr = '0; wdata = '0; ack = 1'b0; err = 1'b0; dat_i = '0;
        last[0] = '0; last[1] = '0;
        stb_cnt[0] = 0; stb_cnt[1] = 0;
        repeat (3) step();
        @(negedge CLK_I);
        chk("rst_w32_outputs", {a_odata, a_busy, a_done, a_err, a_cyc, a_stb, a_we, a_sel, 22'b0}, 64'd0);
        chk("rst_w32_bus", {a_adr, a_dat}, 64'd0);
        chk("rst_w64_outputs", {b_odata, b_busy, b_done, b_err, b_cyc, b_stb, b_we, b_sel, 18'b0}, 64'd0);
        chk("rst_w64_bus", {b_adr, 32'b0}, 64'd0);
        chk("rst_w64_dat", b_dat, 64'd0);
        step();
        RST_I = 1'b0;
        mon_en = 1'b1;

        do_req(BUSOP_WRITEB, 32'h103, 32'hA5, 64'h0, 0, 2);
        do_req(BUSOP_READH, 32'h202, 32'h0, 64'h0000_0000_8001_0000, 0, 0);
        do_req(BUSOP_READHU, 32'h202, 32'h0, 64'h0000_0000_8001_0000, 0, 1);
        do_req(BUSOP_READW, 32'h1004, 32'h0, 64'h1234_5678_9ABC_DEF0, 0, 1);
        do_req(BUSOP_READW, 32'h2, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        do_req(BUSOP_READB, 32'h5, 32'h0, 64'h0, 2, 0);
        do_req(BUSOP_READW, 32'h8, 32'h0, 64'hCAFE_F00D_0BAD_BEEF, 0, TO);
        do_req(BUSOP_READB, 32'h9, 32'h0, 64'h0, 3, 0);
        do_req(BUSOP_WRITEH, 32'h6, 32'h1234_BEEF, 64'h0, 1, 2);

        // Reset while waiting on the slave: request is dropped silently.
        step();
        mon_en = 1'b0;
        junk(1'b1);
        op = BUSOP_READW; addr = 32'h40; ack = 1'b0; err = 1'b0;
        step();
        junk(1'b0); ack = 1'b0; err = 1'b0;
        step();
        junk(1'b0); ack = 1'b0; err = 1'b0;
        RST_I = 1'b1;
        step();
        RST_I = 1'b0;
        junk(1'b0);
        @(negedge CLK_I);
        chk("midrst_w32_cyc_stb", {a_cyc, a_stb}, 64'd0);
        chk("midrst_w64_cyc_stb", {b_cyc, b_stb}, 64'd0);
        chk("midrst_w32_done_busy", {a_done, a_busy}, 64'd0);
        chk("midrst_w64_done_busy", {b_done, b_busy}, 64'd0);
        step();
        junk(1'b0);
        @(negedge CLK_I);
        chk("midrst_w32_no_done", a_done, 64'd0);
        chk("midrst_w64_no_done", b_done, 64'd0);
        chk("midrst_w32_odata", a_odata, 64'd0);
        chk("midrst_w64_odata", b_odata, 64'd0);
        last[0] = '0;
        last[1] = '0;
        stb_cnt[0] = 0;
        stb_cnt[1] = 0;
        step();
        junk(1'b0);
        mon_en = 1'b1;
        do_req(BUSOP_READW, 32'h44, 32'h0, 64'h0000_0000_1357_9BDF, 0, 1);

        for (int t = 0; t < 200; t++) begin
            m  = $urandom_range(0, 9);
            md = (m <= 5) ? 0 : (m == 6) ? 1 : (m == 7) ? 3 : 2;
            do_req(3'($urandom), $urandom, $urandom, {$urandom, $urandom}, md, $urandom_range(0, TO));
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
        end

        gap(3);
        chk("w32_queue_drained", 64'(q0.size()), 64'd0);
        chk("w64_queue_drained", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
